// File: rtl/hp_ram_slave.sv
// Single-beat AXI3 slave backed by an internal word RAM; one transaction in flight,
// bursts and malformed beats are answered with an error response instead of executed.
`timescale 1ns/1ps
module hp_ram_slave #(
   parameter logic [31:0] ADDR_BASE   = 32'h4000_0000,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [31:0] awaddr_i,
   input  logic [5:0]  awid_i,
   input  logic [3:0]  awlen_i,
   input  logic [2:0]  awsize_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wlast_i,
   input  logic [5:0]  wid_i,
   output logic        bvalid_o,
   input  logic        bready_i,
   output logic [1:0]  bresp_o,
   output logic [5:0]  bid_o,
   input  logic        arvalid_i,
   output logic        arready_o,
   input  logic [31:0] araddr_i,
   input  logic [5:0]  arid_i,
   input  logic [3:0]  arlen_i,
   input  logic [2:0]  arsize_i,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic [5:0]  rid_o,
   output logic        rlast_o,
   output logic [15:0] wr_count_o,
   output logic [15:0] rd_count_o,
   output logic [15:0] err_count_o,
   output logic [2:0]  state_o
);

   // Handshakes: a channel transfers on a rising edge where valid and ready are both
   // high; the valid side holds its payload stable until then, ready may change freely.

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE, ST_W_COLLECT, ST_B_RESP, ST_R_FETCH, ST_R_RESP
   } state_t;

   state_t state_q, state_d;
   logic aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [15:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d, err_count_q, err_count_d;

   logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q;
   logic [5:0]  awid_q, wid_q, arid_q, bid_q, rid_q;
   logic [3:0]  awlen_q, wstrb_q, arlen_q;
   logic [2:0]  awsize_q, arsize_q;
   logic        wlast_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] ram_q [DEPTH_WORDS];

   logic aw_hs, w_hs, ar_hs, commit;
   logic [31:0] eff_awaddr, eff_wdata;
   logic [5:0]  eff_awid, eff_wid;
   logic [3:0]  eff_awlen, eff_wstrb;
   logic [2:0]  eff_awsize;
   logic        eff_wlast;
   logic [1:0]  wr_resp, rd_resp;

   function automatic logic [1:0] check_resp(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [2:0] size, input logic beat_ok);
      logic [1:0] resp;
      resp = RESP_OKAY;
      if (({1'b0, addr} < {1'b0, ADDR_BASE}) || ({1'b0, addr} >= ADDR_END))
         resp = RESP_DECERR;
      else if ((len != 4'd0) || (size != 3'b010) || (addr[1:0] != 2'b00) || !beat_ok)
         resp = RESP_SLVERR;
      return resp;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      return IDX_W'((addr - ADDR_BASE) >> 2);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   always_comb begin
      awready_o = 1'b0;
      wready_o  = 1'b0;
      arready_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            awready_o = 1'b1;
            wready_o  = 1'b1;
            arready_o = !awvalid_i && !wvalid_i;
         end
         ST_W_COLLECT: begin
            awready_o = !aw_held_q;
            wready_o  = !w_held_q;
         end
         default: ;
      endcase
      if (reset) begin
         awready_o = 1'b0;
         wready_o  = 1'b0;
         arready_o = 1'b0;
      end
   end

   assign aw_hs = awvalid_i && awready_o;
   assign w_hs  = wvalid_i && wready_o;
   assign ar_hs = arvalid_i && arready_o;

   // The commit cycle sees the half already held plus the half arriving right now.
   assign eff_awaddr = aw_held_q ? awaddr_q : awaddr_i;
   assign eff_awid   = aw_held_q ? awid_q   : awid_i;
   assign eff_awlen  = aw_held_q ? awlen_q  : awlen_i;
   assign eff_awsize = aw_held_q ? awsize_q : awsize_i;
   assign eff_wdata  = w_held_q  ? wdata_q  : wdata_i;
   assign eff_wstrb  = w_held_q  ? wstrb_q  : wstrb_i;
   assign eff_wlast  = w_held_q  ? wlast_q  : wlast_i;
   assign eff_wid    = w_held_q  ? wid_q    : wid_i;

   assign commit  = ((state_q == ST_IDLE) || (state_q == ST_W_COLLECT)) &&
                    (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_resp = check_resp(eff_awaddr, eff_awlen, eff_awsize,
                               eff_wlast && (eff_wid == eff_awid));
   assign rd_resp = check_resp(araddr_q, arlen_q, arsize_q, 1'b1);

   always_comb begin
      state_d     = state_q;
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      wr_count_d  = wr_count_q;
      rd_count_d  = rd_count_q;
      err_count_d = err_count_q;
      case (state_q)
         ST_IDLE, ST_W_COLLECT: begin
            aw_held_d = aw_held_q || aw_hs;
            w_held_d  = w_held_q || w_hs;
            if (commit)
               state_d = ST_B_RESP;
            else if (aw_hs || w_hs)
               state_d = ST_W_COLLECT;
            else if (ar_hs)
               state_d = ST_R_FETCH;
         end
         ST_B_RESP: begin
            if (bready_i) begin
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_count_d = sat_inc(wr_count_q);
               if (bresp_q != RESP_OKAY) err_count_d = sat_inc(err_count_q);
               state_d = ST_IDLE;
            end
         end
         ST_R_FETCH: state_d = ST_R_RESP;
         ST_R_RESP: begin
            if (rready_i) begin
               rd_count_d = sat_inc(rd_count_q);
               if (rresp_q != RESP_OKAY) err_count_d = sat_inc(err_count_q);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         wr_count_q  <= '0;
         rd_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         aw_held_q   <= aw_held_d;
         w_held_q    <= w_held_d;
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
         err_count_q <= err_count_d;
      end
   end

   // Payload and RAM: not reset, only qualified by handshakes and state.
   always_ff @(posedge clock) begin
      if (aw_hs) begin
         awaddr_q <= awaddr_i;
         awid_q   <= awid_i;
         awlen_q  <= awlen_i;
         awsize_q <= awsize_i;
      end
      if (w_hs) begin
         wdata_q <= wdata_i;
         wstrb_q <= wstrb_i;
         wlast_q <= wlast_i;
         wid_q   <= wid_i;
      end
      if (ar_hs) begin
         araddr_q <= araddr_i;
         arid_q   <= arid_i;
         arlen_q  <= arlen_i;
         arsize_q <= arsize_i;
      end
      if (commit) begin
         bresp_q <= wr_resp;
         bid_q   <= eff_awid;
         if (wr_resp == RESP_OKAY) begin
            for (int b = 0; b < 4; b++) begin
               if (eff_wstrb[b]) ram_q[word_idx(eff_awaddr)][8*b +: 8] <= eff_wdata[8*b +: 8];
            end
         end
      end
      if (state_q == ST_R_FETCH) begin
         rid_q   <= arid_q;
         rresp_q <= rd_resp;
         rdata_q <= (rd_resp == RESP_OKAY) ? ram_q[word_idx(araddr_q)] : 32'h0;
      end
   end

   assign bvalid_o    = (state_q == ST_B_RESP);
   assign bresp_o     = bresp_q;
   assign bid_o       = bid_q;
   assign rvalid_o    = (state_q == ST_R_RESP);
   assign rlast_o     = rvalid_o;
   assign rdata_o     = rdata_q;
   assign rresp_o     = rresp_q;
   assign rid_o       = rid_q;
   assign wr_count_o  = wr_count_q;
   assign rd_count_o  = rd_count_q;
   assign err_count_o = err_count_q;
   assign state_o     = state_q;

endmodule
